// File: rtl/dac_frame_rx.sv
// Serial DAC frame receiver: oversamples sclk/sync/din, reassembles 24-bit frames, keeps per-channel samples.
// Latency: SYNC_STAGES+1 clk from the sampled 24th sclk fall (or sync rise) to the output pulse; busy one cycle earlier.
// Backpressure: none; the serial side cannot be stalled, so malformed frames are flagged and dropped.
module dac_frame_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  CMD_WRITE   = 4'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk_in,
    input  logic        sync_in,
    input  logic        din_in,
    output logic        frame_valid,
    output logic [1:0]  frame_ch,
    output logic [15:0] frame_data,
    output logic [15:0] ch0_data,
    output logic [15:0] ch1_data,
    output logic [15:0] ch2_data,
    output logic [15:0] ch3_data,
    output logic        err_short,
    output logic        err_long,
    output logic        err_cmd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_HIGH} state_t;

    logic [SYNC_STAGES-1:0] sclk_sr, sync_sr, din_sr;
    logic                   sclk_d, sync_d;
    logic                   sclk_s, sync_s, din_s;
    logic                   sclk_fall, sync_fall, sync_rise;

    state_t      state, state_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [23:0] shreg, shreg_nxt;
    logic        overrun, overrun_nxt;
    logic        word_det, short_det, long_det;
    logic        word_pend, short_pend, long_pend;
    logic        cmd_ok;
    logic [15:0] ch_reg [4];

    // Synchronizers reset to 0 so a sync held low across reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sr <= '0;
            sync_sr <= '0;
            din_sr  <= '0;
            sclk_d  <= 1'b0;
            sync_d  <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk_in};
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], sync_in};
            din_sr  <= {din_sr[SYNC_STAGES-2:0], din_in};
            sclk_d  <= sclk_s;
            sync_d  <= sync_s;
        end
    end

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign sync_s    = sync_sr[SYNC_STAGES-1];
    assign din_s     = din_sr[SYNC_STAGES-1];
    assign sclk_fall = sclk_d & ~sclk_s;
    assign sync_fall = sync_d & ~sync_s;
    assign sync_rise = ~sync_d & sync_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            overrun    <= 1'b0;
            word_pend  <= 1'b0;
            short_pend <= 1'b0;
            long_pend  <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            overrun    <= overrun_nxt;
            word_pend  <= word_det;
            short_pend <= short_det;
            long_pend  <= long_det;
        end
    end

    // A sync rise takes priority over a coincident sclk fall: the bit is dropped.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        overrun_nxt = overrun;
        word_det    = 1'b0;
        short_det   = 1'b0;
        long_det    = 1'b0;
        case (state)
            IDLE: begin
                if (sync_fall) begin
                    bit_cnt_nxt = '0;
                    shreg_nxt   = '0;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (sync_rise) begin
                    short_det = 1'b1;
                    state_nxt = IDLE;
                end else if (sclk_fall) begin
                    shreg_nxt   = {shreg[22:0], din_s};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd23) begin
                        word_det  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (sync_rise) begin
                    long_det    = overrun;
                    overrun_nxt = 1'b0;
                    state_nxt   = IDLE;
                end else if (sclk_fall) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // shreg is frozen in WAIT_HIGH, so decoding one cycle after the last bit is safe.
    assign cmd_ok = (shreg[23:20] == CMD_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            err_cmd     <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_ch    <= '0;
            frame_data  <= '0;
            for (int i = 0; i < 4; i++) ch_reg[i] <= '0;
        end else begin
            frame_valid <= word_pend & cmd_ok;
            err_cmd     <= word_pend & ~cmd_ok;
            err_short   <= short_pend;
            err_long    <= long_pend;
            if (word_pend && cmd_ok) begin
                frame_ch                <= shreg[18:17];
                frame_data              <= shreg[15:0];
                ch_reg[shreg[18:17]]    <= shreg[15:0];
            end
        end
    end

    assign ch0_data = ch_reg[0];
    assign ch1_data = ch_reg[1];
    assign ch2_data = ch_reg[2];
    assign ch3_data = ch_reg[3];
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dac_frame_rx.sv
// Bench for dac_frame_rx: sample-level reference model of the serial protocol plus directed frames.
module tb_dac_frame_rx;
    localparam int SS   = 2;
    localparam int MAXC = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk_in = 1'b0, sync_in = 1'b1, din_in = 1'b0;
    logic        frame_valid, err_short, err_long, err_cmd, busy;
    logic [1:0]  frame_ch;
    logic [15:0] frame_data, ch0_data, ch1_data, ch2_data, ch3_data;

    dac_frame_rx #(.SYNC_STAGES(SS), .CMD_WRITE(4'h1)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk_in), .sync_in(sync_in), .din_in(din_in),
        .frame_valid(frame_valid), .frame_ch(frame_ch), .frame_data(frame_data),
        .ch0_data(ch0_data), .ch1_data(ch1_data), .ch2_data(ch2_data), .ch3_data(ch3_data),
        .err_short(err_short), .err_long(err_long), .err_cmd(err_cmd), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int edge_cnt = 0;
    int cnt_fv = 0, cnt_short = 0, cnt_long = 0, cnt_cmd = 0;
    bit sweep_on = 1'b0;

    // Expected output events, indexed by the clk edge after which they are visible.
    bit          ev_fv [MAXC], ev_cmd [MAXC], ev_short [MAXC], ev_long [MAXC];
    bit          ev_bset [MAXC], ev_bclr [MAXC];
    logic [1:0]  ev_ch [MAXC];
    logic [15:0] ev_dat [MAXC];

    logic        m_fv = 0, m_cmd = 0, m_short = 0, m_long = 0, m_busy = 0;
    logic [1:0]  m_ch = 0;
    logic [15:0] m_dat = 0;
    logic [15:0] m_reg [4] = '{default: 16'h0};
    logic        p_sclk = 0, p_sync = 0;
    bit          in_frame = 0;
    int          nbits = 0, fall24_edge = 0;
    logic [23:0] word = 0;

    always @(posedge clk) begin
        int e;
        edge_cnt = edge_cnt + 1;
        e = edge_cnt;
        m_fv = 0; m_cmd = 0; m_short = 0; m_long = 0;
        if (rst) begin
            m_busy = 0; m_ch = 0; m_dat = 0;
            for (int i = 0; i < 4; i++) m_reg[i] = 16'h0;
            for (int t = e; t <= e + SS + 1 && t < MAXC; t++) begin
                ev_fv[t] = 0; ev_cmd[t] = 0; ev_short[t] = 0; ev_long[t] = 0;
                ev_bset[t] = 0; ev_bclr[t] = 0;
            end
            p_sclk = 0; p_sync = 0; in_frame = 0;
        end else if (e + SS + 1 < MAXC) begin
            if (ev_fv[e]) begin
                m_fv = 1; m_ch = ev_ch[e]; m_dat = ev_dat[e]; m_reg[ev_ch[e]] = ev_dat[e];
            end
            m_cmd = ev_cmd[e]; m_short = ev_short[e]; m_long = ev_long[e];
            if (ev_bset[e]) m_busy = 1;
            if (ev_bclr[e]) m_busy = 0;
            if (!in_frame) begin
                if (p_sync && !sync_in) begin
                    in_frame = 1; nbits = 0; word = 0; ev_bset[e + SS] = 1;
                end
            end else if (!p_sync && sync_in) begin
                if (nbits < 24) ev_short[e + SS + 1] = 1;
                else if (nbits > 24) ev_long[e + SS + 1] = 1;
                in_frame = 0; ev_bclr[e + SS] = 1;
            end else if (p_sclk && !sclk_in) begin
                nbits++;
                if (nbits <= 24) word = {word[22:0], din_in};
                if (nbits == 24) begin
                    fall24_edge = e;
                    if (word[23:20] == 4'h1) begin
                        ev_fv[e + SS + 1] = 1; ev_ch[e + SS + 1] = word[18:17];
                        ev_dat[e + SS + 1] = word[15:0];
                    end else begin
                        ev_cmd[e + SS + 1] = 1;
                    end
                end
            end
            p_sclk = sclk_in; p_sync = sync_in;
        end
    end

    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            n_cmp++;
            if ({frame_valid, frame_ch, frame_data, ch0_data, ch1_data, ch2_data, ch3_data,
                 err_short, err_long, err_cmd, busy} !==
                {m_fv, m_ch, m_dat, m_reg[0], m_reg[1], m_reg[2], m_reg[3],
                 m_short, m_long, m_cmd, m_busy}) begin
                n_bad++;
                $display("FAIL cycle %0d: dut fv=%b ch=%0d dat=%h regs=%h/%h/%h/%h short=%b long=%b cmd=%b busy=%b | exp fv=%b ch=%0d dat=%h regs=%h/%h/%h/%h short=%b long=%b cmd=%b busy=%b",
                         edge_cnt, frame_valid, frame_ch, frame_data, ch0_data, ch1_data, ch2_data, ch3_data,
                         err_short, err_long, err_cmd, busy, m_fv, m_ch, m_dat, m_reg[0], m_reg[1],
                         m_reg[2], m_reg[3], m_short, m_long, m_cmd, m_busy);
            end
            if (sweep_on && frame_valid === 1'b1) begin
                n_cmp++;
                if (edge_cnt - fall24_edge != SS + 1) begin
                    n_bad++;
                    $display("FAIL latency: got %0d cycles want %0d", edge_cnt - fall24_edge, SS + 1);
                end
            end
            cnt_fv    += (frame_valid === 1'b1);
            cnt_short += (err_short === 1'b1);
            cnt_long  += (err_long === 1'b1);
            cnt_cmd   += (err_cmd === 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_fv = 0; cnt_short = 0; cnt_long = 0; cnt_cmd = 0;
    endtask

    task automatic step(input int n, input int ph);
        repeat (n) @(posedge clk);
        #ph;
    endtask

    task automatic toggle(input int n, input int h, input int ph);
        for (int i = 0; i < n; i++) begin
            din_in = 1'($urandom_range(0, 1));
            sclk_in = 1'b1; step(h, ph);
            sclk_in = 1'b0; step(h, ph);
        end
    endtask

    // Data launched on the sclk rise, so it is stable across the sampling fall.
    task automatic send(input logic [23:0] w, input int nf, input int h, input int ph, input int gap);
        @(posedge clk); #ph;
        sync_in = 1'b0;
        step(h, ph);
        for (int i = 0; i < nf; i++) begin
            din_in = (i < 24) ? w[23 - i] : 1'($urandom_range(0, 1));
            sclk_in = 1'b1; step(h, ph);
            sclk_in = 1'b0; step(h, ph);
        end
        sync_in = 1'b1; din_in = 1'b0;
        step(gap, ph);
    endtask

    initial begin
        logic [15:0] last [4];
        logic [15:0] d;
        logic [1:0]  c;
        logic [7:0]  hdr;
        int          h, ph;

        for (int i = 0; i < 4; i++) last[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step(4, 1);
        check("reset_ch0", {16'h0, ch0_data}, 32'h0);
        check("reset_ch3", {16'h0, ch3_data}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);

        clear_counts();
        send(24'h108000, 24, 2, 3, 4);
        step(8, 1);
        check("t1_fv_count", cnt_fv, 1);
        check("t1_frame_ch", {30'h0, frame_ch}, 0);
        check("t1_frame_data", {16'h0, frame_data}, 32'h8000);
        check("t1_ch0", {16'h0, ch0_data}, 32'h8000);
        check("t1_ch1", {16'h0, ch1_data}, 32'h0);

        clear_counts();
        send(24'h100000, 24, 2, 2, 2);
        send(24'h122ecc, 24, 2, 2, 2);
        send(24'h14fd89, 24, 2, 2, 2);
        send(24'h167374, 24, 2, 2, 2);
        step(8, 1);
        check("t2_fv_count", cnt_fv, 4);
        check("t2_err_count", cnt_short + cnt_long + cnt_cmd, 0);
        check("t2_ch0", {16'h0, ch0_data}, 32'h0000);
        check("t2_ch1", {16'h0, ch1_data}, 32'h2ecc);
        check("t2_ch2", {16'h0, ch2_data}, 32'hfd89);
        check("t2_ch3", {16'h0, ch3_data}, 32'h7374);
        check("t2_frame_ch", {30'h0, frame_ch}, 3);

        clear_counts();
        send(24'h16ffff, 12, 3, 7, 4);
        step(8, 1);
        check("t3_short_count", cnt_short, 1);
        check("t3_fv_count", cnt_fv, 0);
        check("t3_ch3", {16'h0, ch3_data}, 32'h7374);

        clear_counts();
        send(24'h20ffff, 24, 2, 4, 3);
        step(8, 1);
        check("t4_cmd_count", cnt_cmd, 1);
        check("t4_ch1_kept", {16'h0, ch1_data}, 32'h2ecc);
        check("t4_frame_data_kept", {16'h0, frame_data}, 32'h7374);
        clear_counts();
        send(24'h121234, 26, 2, 6, 3);
        step(8, 1);
        check("t4_fv_count", cnt_fv, 1);
        check("t4_ch1", {16'h0, ch1_data}, 32'h1234);
        check("t4_long_count", cnt_long, 1);
        check("t4_short_count", cnt_short, 0);

        clear_counts();
        @(posedge clk); #4 sync_in = 1'b0;
        step(2, 4);
        toggle(10, 3, 4);
        rst = 1'b1; step(2, 4); rst = 1'b0;
        toggle(30, 3, 4);
        sync_in = 1'b1;
        step(3, 4);
        step(6, 1);
        check("t5_quiet_pulses", cnt_fv + cnt_short + cnt_long + cnt_cmd, 0);
        check("t5_busy_idle", {31'h0, busy}, 0);
        send(24'h14abcd, 24, 3, 4, 4);
        step(8, 1);
        check("t5_fv_count", cnt_fv, 1);
        check("t5_ch2", {16'h0, ch2_data}, 32'habcd);
        check("t5_ch1_reset", {16'h0, ch1_data}, 32'h0);

        for (int i = 0; i < 4; i++) last[i] = 16'h0;
        last[2] = 16'habcd;
        clear_counts();
        sweep_on = 1'b1;
        for (int i = 0; i < 13; i++) begin
            h   = 2 + (i % 7);
            ph  = $urandom_range(1, 9);
            c   = 2'(i);
            d   = 16'($urandom);
            hdr = {4'h1, 1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 1))};
            last[c] = d;
            send({hdr, d}, 24, h, ph, 2 + (i % 3));
        end
        step(8, 1);
        sweep_on = 1'b0;
        check("t6_fv_count", cnt_fv, 13);
        check("t6_err_count", cnt_short + cnt_long + cnt_cmd, 0);
        check("t6_ch0", {16'h0, ch0_data}, {16'h0, last[0]});
        check("t6_ch1", {16'h0, ch1_data}, {16'h0, last[1]});
        check("t6_ch2", {16'h0, ch2_data}, {16'h0, last[2]});
        check("t6_ch3", {16'h0, ch3_data}, {16'h0, last[3]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dac_frame_rx.md
# dac_frame_rx

Serial frame receiver for the 24-bit DAC write protocol: 8-bit header plus 16-bit sample, MSB first, framed by active-low sync, with data launched on the rising edge of the serial clock. The block oversamples sclk/sync/din on the system clock and reassembles each frame. It decodes the header into a command and a 2-bit channel and keeps a per-channel register of the last written sample. It serves as the loopback checker and DAC model on the board and in simulation.

## Interface

- SYNC_STAGES, 2: synchronizer depth on sclk_in, sync_in and din_in (≥2)
- CMD_WRITE, 4'h1: header[7:4] value accepted as a write
- clk  in  1  system clock; ≥4× sclk_in frequency, sclk high and low phases ≥2 clk each
- rst  in  1  reset, synchronous, active-high
- sclk_in  in  1  serial clock from the transmitter, asynchronous
- sync_in  in  1  frame strobe, active-low, asynchronous
- din_in  in  1  serial data, asynchronous
- frame_valid  out  1  one-cycle pulse: a good write frame was captured
- frame_ch  out  2  channel of the last good frame (header[2:1])
- frame_data  out  16  sample of the last good frame
- ch0_data, ch1_data, ch2_data, ch3_data  out  16 each  last sample written per channel
- err_short  out  1  one-cycle pulse: sync rose before 24 bits
- err_long  out  1  one-cycle pulse: more than 24 sclk falls inside one sync-low window
- err_cmd  out  1  one-cycle pulse: 24 bits received, header[7:4] ≠ CMD_WRITE
- busy  out  1  high while in SHIFT or WAIT_HIGH

## Operation

- Inputs pass through SYNC_STAGES flops. Edge detect on the synced sclk and sync uses one extra register.
- States: IDLE, SHIFT, WAIT_HIGH.
- IDLE: a falling edge of synced sync clears bit_cnt (5 bits) and the shift register and moves to SHIFT. A sync that is already low does not start a frame.
- SHIFT: each synced sclk falling edge with sync low shifts din into a 24-bit register, LSB in, and increments bit_cnt.
  - On the 24th fall, the header is decoded. If shreg[23:20] == CMD_WRITE: frame_valid pulses, frame_ch = shreg[18:17], frame_data = shreg[15:0], and ch[frame_ch]_data is updated. Otherwise err_cmd pulses and no register changes. Header bits 19 and 16 are ignored.
  - After the 24th fall, go to WAIT_HIGH.
  - If sync rises with bit_cnt < 24, err_short pulses and the state returns to IDLE. bit_cnt = 0 is included.
- WAIT_HIGH: extra sclk falls set a sticky overrun flag. When sync rises, err_long pulses if overrun is set, overrun clears, and the state returns to IDLE.
- A sync rise and an sclk fall in the same cycle: the sync rise wins and the bit is not taken.
- Reset values: state IDLE, all outputs 0, all channel registers 0, counters 0.
- Reset mid-frame aborts the frame with no error pulse. After reset, a frame starts only on a later falling edge of sync, so a sync that is held low across reset is ignored until it goes high.

## Timing

- Let edge N be the first clk edge that samples sclk_in low (the falling edge). The bit is shifted at edge N+SYNC_STAGES.
- For the 24th bit, frame_valid, frame_ch/data, chX_data or err_cmd become visible after edge N+SYNC_STAGES+1.
- err_short and err_long become visible SYNC_STAGES+1 edges after sync_in is first sampled high.
- All pulses last exactly one clk. frame_ch, frame_data and chX_data hold until the next good frame or reset.
- Back-to-back frames are supported when sync stays high for ≥2 clk after synchronization.
- busy rises the cycle after the sync fall is detected and falls the cycle after the sync rise is detected.

## Test plan

- Header 0x10 with data 0x8000, sclk = clk/4: frame_valid 1 cycle, frame_ch=0, frame_data=0x8000, ch0_data=0x8000, other channels 0.
- Four consecutive frames with headers 0x10/0x12/0x14/0x16 and data 0x0000/0x2ecc/0xfd89/0x7374, 2-clk sync-high gaps: ch0..ch3 = 0x0000/0x2ecc/0xfd89/0x7374, four frame_valid pulses, no errors.
- Sync low for 12 sclk falls, then high: err_short pulses once, no frame_valid, channel registers unchanged.
- Header 0x20 with data 0xffff: err_cmd pulses, ch registers unchanged. Then a 26-fall frame with header 0x12 and data 0x1234: frame_valid, ch1_data=0x1234, then err_long at the sync rise.
- rst asserted after 10 bits with sync held low through 30 more sclk falls, then a valid 0x14/0xabcd frame: no pulses during the held-low window, then ch2_data=0xabcd.
- Sweep sclk = clk/4..clk/16 with random phase against clk: every frame decoded, latency exactly SYNC_STAGES+1 cycles from the sampled 24th fall.
